// File: rtl/chunked_serial_subtractor.sv
// chunked_serial_subtractor: multi-cycle unsigned subtractor D = A - B.
// Processes CHUNK_LEN bits per cycle, LSB chunk first, and registers the
// borrow between chunks. Valid/ready handshake on both input and output.
// Optional macro SERIAL_SUB_SIGNED_OVF_EN adds an 'overflow' output that
// flags signed two's-complement overflow of A - B.
module chunked_serial_subtractor #(
  parameter int unsigned BIT_LEN   = 256,
  parameter int unsigned CHUNK_LEN = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BIT_LEN-1:0] A,
  input  logic [BIT_LEN-1:0] B,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BIT_LEN-1:0] D,
  output logic               borrow_out
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  ,
  output logic               overflow
`endif
);

  localparam int unsigned NUM_CHUNKS = BIT_LEN / CHUNK_LEN;
  localparam int unsigned CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NUM_CHUNKS - 1);

  // Operand width must split into whole chunks.
  generate
    if ((BIT_LEN % CHUNK_LEN) != 0) begin : g_bad_chunk
      $error("chunked_serial_subtractor: BIT_LEN must be a multiple of CHUNK_LEN");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               borrow_q, borrow_d;
  logic [BIT_LEN-1:0] a_q, a_d;
  logic [BIT_LEN-1:0] b_q, b_d;
  logic [BIT_LEN-1:0] d_q, d_d;
  logic               bout_q, bout_d;

  logic [CHUNK_LEN-1:0] a_chunk;
  logic [CHUNK_LEN-1:0] b_chunk;
  logic [CHUNK_LEN-1:0] diff;
  logic                 b_next;
  int unsigned          chunk_off;

`ifdef SERIAL_SUB_SIGNED_OVF_EN
  logic ovf_q, ovf_d;
`endif

  // Chunk datapath: select the current chunk and subtract with incoming borrow.
  always_comb begin
    chunk_off = CHUNK_LEN * 32'(cnt_q);
    a_chunk   = a_q[chunk_off +: CHUNK_LEN];
    b_chunk   = b_q[chunk_off +: CHUNK_LEN];
    {b_next, diff} = {1'b0, a_chunk} - {1'b0, b_chunk} - {{CHUNK_LEN{1'b0}}, borrow_q};
  end

  // Next-state and handshake logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    borrow_d  = borrow_q;
    a_d       = a_q;
    b_d       = b_q;
    d_d       = d_q;
    bout_d    = bout_q;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    ovf_d     = ovf_q;
`endif
    in_ready  = 1'b0;
    out_valid = 1'b0;

    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d      = A;
          b_d      = B;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end

      RUN: begin
        d_d[chunk_off +: CHUNK_LEN] = diff;
        borrow_d = b_next;
        if (cnt_q == LAST_CHUNK) begin
          bout_d  = b_next;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
          // Final chunk carries the result MSB; operand MSBs come from the latches.
          ovf_d   = (a_q[BIT_LEN-1] != b_q[BIT_LEN-1]) &&
                    (diff[CHUNK_LEN-1] != a_q[BIT_LEN-1]);
`endif
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      d_q      <= '0;
      bout_q   <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      a_q      <= a_d;
      b_q      <= b_d;
      d_q      <= d_d;
      bout_q   <= bout_d;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  // Registered result outputs.
  always_comb begin
    D          = d_q;
    borrow_out = bout_q;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    overflow   = ovf_q;
`endif
  end

endmodule

// File: tb/tb_chunked_serial_subtractor.sv
// Scoreboard bench for chunked_serial_subtractor: instance 0 is 16/4
// (four chunks), instance 1 is 16/16 (single chunk). Optional macro
// SERIAL_SUB_SIGNED_OVF_EN enables the overflow port and its checks.
module tb_chunked_serial_subtractor;

  typedef struct {
    int          id;
    logic [15:0] d;
    logic        bo;
    logic        ovf;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iv  [2];
  logic        ir  [2];
  logic        ov  [2];
  logic        orr [2];
  logic        bo  [2];
  logic [15:0] a   [2];
  logic [15:0] b   [2];
  logic [15:0] d   [2];
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  logic        ovf [2];
`endif

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  exp_t q[$];

  logic [15:0] hd [2];
  logic        hb [2];
  logic        pv [2];
  logic        jp [2];

  chunked_serial_subtractor #(.BIT_LEN(16), .CHUNK_LEN(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .A(a[0]), .B(b[0]), .out_valid(ov[0]), .out_ready(orr[0]),
    .D(d[0]), .borrow_out(bo[0])
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    , .overflow(ovf[0])
`endif
  );

  chunked_serial_subtractor #(.BIT_LEN(16), .CHUNK_LEN(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .A(a[1]), .B(b[1]), .out_valid(ov[1]), .out_ready(orr[1]),
    .D(d[1]), .borrow_out(bo[1])
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    , .overflow(ovf[1])
`endif
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Reference: plain modular arithmetic and unsigned/signed comparisons.
  function automatic exp_t model(input int id, input logic [15:0] av, input logic [15:0] bv);
    exp_t e;
    logic signed [16:0] sd;
    e.id  = id;
    e.d   = av - bv;
    e.bo  = (av < bv);
    sd    = $signed({av[15], av}) - $signed({bv[15], bv});
    e.ovf = (sd > 17'sd32767) || (sd < -17'sd32768);
    e.acc = 0;
    return e;
  endfunction

  function automatic int nch(input int id);
    return (id == 0) ? 4 : 1;
  endfunction

  task automatic issue(input int id, input logic [15:0] av, input logic [15:0] bv);
    int   n;
    exp_t e;
    @(negedge clk);
    iv[id] = 1'b1;
    a[id]  = av;
    b[id]  = bv;
    n = 0;
    while (!ir[id] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ir[id]) begin
      chk("accept_timeout", 32'(ir[id]), 1);
      iv[id] = 1'b0;
    end else begin
      e     = model(id, av, bv);
      e.acc = cyc + 1;
      q.push_back(e);
      @(posedge clk);
      #1;
      iv[id] = 1'b0;
      a[id]  = 16'($urandom);
      b[id]  = 16'($urandom);
    end
  endtask

  task automatic drain(input int id, input bit rnd);
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      orr[id] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      n++;
    end
    chk("drain_timeout", 32'(q.size()), 0);
    @(negedge clk);
    orr[id] = 1'b1;
  endtask

  // Monitor: latency, hold stability under backpressure, and result checks.
  initial begin
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      pv[i] = 1'b0;
      jp[i] = 1'b0;
      hd[i] = '0;
      hb[i] = 1'b0;
    end
    forever begin
      @(negedge clk);
      #2;
      for (int id = 0; id < 2; id++) begin
        if (jp[id]) begin
          chk("ovalid_drop", 32'(ov[id]), 0);
          chk("iready_back", 32'(ir[id]), 1);
          jp[id] = 1'b0;
        end
        if (ov[id]) begin
          chk("iready_in_done", 32'(ir[id]), 0);
          if (!pv[id]) begin
            if (q.size() == 0 || q[0].id != id) chk("spurious_valid", 32'(ov[id]), 0);
            else chk("latency", 32'(cyc - q[0].acc), 32'(nch(id)));
            hd[id] = d[id];
            hb[id] = bo[id];
          end else begin
            chk("hold_D", 32'(d[id]), 32'(hd[id]));
            chk("hold_borrow", 32'(bo[id]), 32'(hb[id]));
          end
          if (orr[id] && q.size() != 0 && q[0].id == id) begin
            e = q.pop_front();
            chk("D", 32'(d[id]), 32'(e.d));
            chk("borrow_out", 32'(bo[id]), 32'(e.bo));
`ifdef SERIAL_SUB_SIGNED_OVF_EN
            chk("overflow", 32'(ovf[id]), 32'(e.ovf));
`endif
            jp[id] = 1'b1;
          end
        end
        pv[id] = ov[id];
      end
    end
  end

  initial begin
    int n;
    logic [15:0] dir_a [8] = '{16'h1000, 16'h0000, 16'h1234, 16'h0000,
                               16'hFFFF, 16'h8000, 16'h7FFF, 16'h0005};
    logic [15:0] dir_b [8] = '{16'h0001, 16'h0001, 16'h1234, 16'hFFFF,
                               16'h0000, 16'h0001, 16'hFFFF, 16'h0003};
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      iv[i] = 1'b0; orr[i] = 1'b1; a[i] = '0; b[i] = '0;
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_in_ready", 32'(ir[i]), 1);
      chk("rst_out_valid", 32'(ov[i]), 0);
      chk("rst_D", 32'(d[i]), 0);
      chk("rst_borrow", 32'(bo[i]), 0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed operands on the four-chunk instance.
    for (int i = 0; i < 8; i++) begin
      issue(0, dir_a[i], dir_b[i]);
      drain(0, 1'b0);
    end

    // Backpressure with a competing input offer while the result is held.
    orr[0] = 1'b0;
    issue(0, 16'h1000, 16'h0001);
    n = 0;
    while (!ov[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid_seen", 32'(ov[0]), 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      iv[0] = 1'b1;
      a[0]  = 16'($urandom);
      b[0]  = 16'($urandom);
    end
    @(negedge clk);
    iv[0]  = 1'b0;
    orr[0] = 1'b1;
    drain(0, 1'b0);

    // Reset in the middle of RUN discards the operation asynchronously.
    issue(0, 16'hFFFF, 16'h0001);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    q.delete();
    jp[0] = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(ov[0]), 0);
    chk("midrst_in_ready", 32'(ir[0]), 1);
    chk("midrst_D", 32'(d[0]), 0);
    chk("midrst_borrow", 32'(bo[0]), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    issue(0, 16'd5, 16'd3);
    drain(0, 1'b0);

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 30; i++) begin
      issue(0, 16'($urandom), 16'($urandom));
      drain(0, 1'b1);
    end

    // Single-chunk instance.
    issue(1, 16'h0003, 16'h0005);
    drain(1, 1'b0);
    issue(1, 16'h8000, 16'h0001);
    drain(1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      issue(1, 16'($urandom), 16'($urandom));
      drain(1, 1'b1);
    end

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
